// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing, operand forwarding selects,
// NZCV status register and bring-up event counters. Macro: FORWARDING_EN.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_valid,
    input  logic [3:0]       ID_src1,
    input  logic [3:0]       ID_src2,
    input  logic             ID_two_src,
    input  logic [3:0]       EX_src1,
    input  logic [3:0]       EX_src2,
    input  logic [3:0]       EX_dest,
    input  logic             EX_WB_EN,
    input  logic             EX_MEM_R_EN,
    input  logic [3:0]       MEM_dest,
    input  logic             MEM_WB_EN,
    input  logic [3:0]       WB_dest,
    input  logic             WB_WB_EN,
    input  logic             EX_S,
    input  logic [3:0]       EX_status,
    input  logic             Branch_taken,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic [3:0]       SR,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       sr_q, sr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;

    // True when a pending write to dest collides with a checked ID source.
    function automatic logic src_hit(input logic we, input logic [3:0] dest);
        return we && ((dest == ID_src1) ||
                      (ID_two_src && (dest == ID_src2)));
    endfunction

`ifdef FORWARDING_EN
    // Youngest producer wins: MEM before WB.
    function automatic logic [1:0] fwd_sel(input logic [3:0] src);
        if (MEM_WB_EN && (MEM_dest == src))
            return 2'd1;
        else if (WB_WB_EN && (WB_dest == src))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    logic unused_fwd;
    assign unused_fwd = EX_WB_EN;

    // Only a load in EX cannot be bypassed; everything else forwards.
    always_comb begin
        hazard   = ID_valid && src_hit(EX_MEM_R_EN, EX_dest);
        sel_src1 = fwd_sel(EX_src1);
        sel_src2 = fwd_sel(EX_src2);
    end
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{EX_src1, EX_src2, EX_MEM_R_EN};

    // Without bypass paths any in-flight writer blocks the reader.
    always_comb begin
        hazard   = ID_valid && (src_hit(EX_WB_EN, EX_dest) ||
                                src_hit(MEM_WB_EN, MEM_dest) ||
                                src_hit(WB_WB_EN, WB_dest));
        sel_src1 = 2'd0;
        sel_src2 = 2'd0;
    end
`endif

    // The stalled instruction is squashed by a taken branch, so flush wins.
    always_comb begin
        flush = Branch_taken;
        stall = hazard && !Branch_taken;
    end

    // Next state for sequencer, status register and counters.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Branch_taken)
            state_d = FLUSH;
        else if (state_q == FLUSH)
            state_d = RUN;
        else if (stall)
            state_d = STALL;
        else
            state_d = RUN;
        if (EX_S)
            sr_d = EX_status;
        if (stall)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (Branch_taken && (state_q != FLUSH))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            sr_q        <= 4'b0000;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign SR        = sr_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed steps for hazard_ctrl with a
// scoreboard queue of expected combinational and registered results.
module tb_hazard_ctrl;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_valid, ID_two_src;
    logic [3:0]  ID_src1, ID_src2;
    logic [3:0]  EX_src1, EX_src2, EX_dest;
    logic        EX_WB_EN, EX_MEM_R_EN;
    logic [3:0]  MEM_dest, WB_dest;
    logic        MEM_WB_EN, WB_WB_EN;
    logic        EX_S, Branch_taken;
    logic [3:0]  EX_status;
    logic        stall, flush;
    logic [1:0]  sel_src1, sel_src2;
    logic [3:0]  SR;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [3:0]  sr;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [1:0]  st;
    } exp_t;

    exp_t comb_q[$];
    exp_t reg_q[$];

    logic [3:0]  sr_m;
    logic [15:0] sc_m, fc_m;
    logic [1:0]  st_m;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .ID_valid(ID_valid), .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_two_src(ID_two_src),
        .EX_src1(EX_src1), .EX_src2(EX_src2), .EX_dest(EX_dest),
        .EX_WB_EN(EX_WB_EN), .EX_MEM_R_EN(EX_MEM_R_EN),
        .MEM_dest(MEM_dest), .MEM_WB_EN(MEM_WB_EN),
        .WB_dest(WB_dest), .WB_WB_EN(WB_WB_EN),
        .EX_S(EX_S), .EX_status(EX_status),
        .Branch_taken(Branch_taken),
        .stall(stall), .flush(flush),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .SR(SR), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ID_valid = 0; ID_two_src = 0; ID_src1 = 0; ID_src2 = 0;
        EX_src1 = 0; EX_src2 = 0; EX_dest = 0;
        EX_WB_EN = 0; EX_MEM_R_EN = 0;
        MEM_dest = 0; MEM_WB_EN = 0; WB_dest = 0; WB_WB_EN = 0;
        EX_S = 0; EX_status = 0; Branch_taken = 0;
    endtask

    task automatic chk_regs(input string tag);
        exp_t e;
        e = reg_q.pop_front();
        chk({tag, ".SR"}, 32'(SR), 32'(e.sr));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
        chk({tag, ".fsm"}, 32'(dut.state_q), 32'(e.st));
    endtask

    // One cycle: check outputs, then advance model and check registers.
    task automatic step(input string tag, input logic es, input logic ef,
                        input logic [1:0] e1, input logic [1:0] e2);
        exp_t e;
        e = '{stall: es, flush: ef, s1: e1, s2: e2,
              sr: 0, sc: 0, fc: 0, st: 0};
        comb_q.push_back(e);
        #1;
        e = comb_q.pop_front();
        chk({tag, ".stall"}, 32'(stall), 32'(e.stall));
        chk({tag, ".flush"}, 32'(flush), 32'(e.flush));
        chk({tag, ".sel_src1"}, 32'(sel_src1), 32'(e.s1));
        chk({tag, ".sel_src2"}, 32'(sel_src2), 32'(e.s2));
        if (EX_S) sr_m = EX_status;
        if (es) sc_m = sc_m + 16'd1;
        if (Branch_taken && st_m != S_FLUSH) fc_m = fc_m + 16'd1;
        if (Branch_taken) st_m = S_FLUSH;
        else if (st_m == S_FLUSH) st_m = S_RUN;
        else st_m = es ? S_STALL : S_RUN;
        reg_q.push_back('{stall: 0, flush: 0, s1: 0, s2: 0,
                          sr: sr_m, sc: sc_m, fc: fc_m, st: st_m});
        @(posedge clk);
        #1;
        chk_regs(tag);
    endtask

    task automatic model_reset();
        sr_m = 4'b0000; sc_m = 0; fc_m = 0; st_m = S_RUN;
        reg_q.push_back('{stall: 0, flush: 0, s1: 0, s2: 0,
                          sr: sr_m, sc: sc_m, fc: fc_m, st: st_m});
    endtask

    initial begin
        clr();
        reset = 0;
        #2;
        model_reset();
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.sel_src1", 32'(sel_src1), 32'd0);
        chk("rst.sel_src2", 32'(sel_src2), 32'd0);
        chk_regs("rst");
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;

        step("idle", 0, 0, 0, 0);
        EX_S = 1; EX_status = 4'b0110;
        step("sr_load", 0, 0, 0, 0);
        EX_S = 0; EX_status = 4'b1111;
        step("sr_hold", 0, 0, 0, 0);

        EX_status = 0;
        ID_valid = 1; ID_src1 = 3; EX_dest = 3;
        EX_WB_EN = 1; EX_MEM_R_EN = 1; Branch_taken = 1;
        step("br_vs_stall", 0, 1, 0, 0);
        step("br_again", 0, 1, 0, 0);
        clr();
        step("br_done", 0, 0, 0, 0);

`ifdef FORWARDING_EN
        ID_valid = 1; ID_src1 = 3; EX_dest = 3;
        EX_WB_EN = 1; EX_MEM_R_EN = 1;
        step("load_use", 1, 0, 0, 0);
        EX_dest = 0; EX_WB_EN = 0; EX_MEM_R_EN = 0;
        MEM_dest = 3; MEM_WB_EN = 1; EX_src1 = 3;
        step("bubble_fwd", 0, 0, 1, 0);
        clr();
        ID_valid = 1; ID_src1 = 1; ID_src2 = 7;
        EX_dest = 7; EX_MEM_R_EN = 1; EX_WB_EN = 1;
        step("src2_unchecked", 0, 0, 0, 0);
        ID_two_src = 1;
        step("src2_checked", 1, 0, 0, 0);
        ID_valid = 0;
        step("id_invalid", 0, 0, 0, 0);
        clr();
        MEM_dest = 5; WB_dest = 5; MEM_WB_EN = 1; WB_WB_EN = 1;
        EX_src1 = 5; EX_src2 = 5;
        step("fwd_mem_prio", 0, 0, 1, 1);
        MEM_WB_EN = 0;
        step("fwd_wb", 0, 0, 2, 2);
        clr();
        ID_valid = 1; ID_src1 = 15; EX_dest = 15;
        EX_MEM_R_EN = 1; EX_WB_EN = 1;
        step("r15", 1, 0, 0, 0);
`else
        ID_valid = 1; ID_src1 = 1; ID_src2 = 2; ID_two_src = 1;
        EX_dest = 2; EX_WB_EN = 1;
        step("nofwd_ex", 1, 0, 0, 0);
        EX_dest = 0; EX_WB_EN = 0; MEM_dest = 2; MEM_WB_EN = 1;
        step("nofwd_mem", 1, 0, 0, 0);
        MEM_dest = 0; MEM_WB_EN = 0; WB_dest = 2; WB_WB_EN = 1;
        step("nofwd_wb", 1, 0, 0, 0);
        WB_dest = 0; WB_WB_EN = 0;
        step("nofwd_clear", 0, 0, 0, 0);
        ID_two_src = 0; EX_dest = 2; EX_WB_EN = 1;
        step("src2_unchecked", 0, 0, 0, 0);
        ID_valid = 0; ID_src1 = 2;
        step("id_invalid", 0, 0, 0, 0);
        clr();
        MEM_dest = 5; WB_dest = 5; MEM_WB_EN = 1; WB_WB_EN = 1;
        EX_src1 = 5; EX_src2 = 5;
        step("sel_tied", 0, 0, 0, 0);
        clr();
        ID_valid = 1; ID_src1 = 15; EX_dest = 15; EX_WB_EN = 1;
        EX_MEM_R_EN = 1;
        step("r15", 1, 0, 0, 0);
`endif

        EX_S = 1; EX_status = 4'b1010;
        step("stall_sr", 1, 0, 0, 0);
        EX_S = 0;
        #2;
        reset = 0;
        #1;
        model_reset();
        chk_regs("mid_rst");
        chk("mid_rst.stall", 32'(stall), 32'd1);
        clr();
        reset = 1;
        step("post_rst", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
